// File: rtl/usb_rst_sequencer_if.sv
// rtl/usb_rst_sequencer_if.sv - Avalon-MM register bus bundle for the USB reset sequencer
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/usb_rst_sequencer.sv
// rtl/usb_rst_sequencer.sv - timed reset pulse and recovery hold-off for the USB OTG controller
module usb_rst_sequencer #(
    parameter logic [23:0] PULSE_DEFAULT   = 24'd50000,
    parameter logic [23:0] RECOVER_DEFAULT = 24'd500000
) (
    input  logic               clk,
    input  logic               reset_n,
    usb_rst_sequencer_if.slave bus,
    output logic               otg_rst_n,
    output logic               irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      r_state;
    logic [23:0] r_count;
    logic        r_done;
    logic        r_otg_rst_n;
    logic        r_irq_en;
    logic        r_manual_en;
    logic        r_manual_lvl;
    logic [23:0] r_pulse_len;
    logic [23:0] r_recover_len;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_abort;
    logic        w_w1c_done;
    logic        w_manual_en_nxt;
    logic        w_manual_lvl_nxt;
    logic        w_idle_pin;
    logic [23:0] w_pulse_load;
    logic [23:0] w_recover_load;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_wr_ctrl  = w_wr & (bus.address == 2'd0);
    assign w_start    = w_wr_ctrl & bus.writedata[0];
    assign w_abort    = w_wr_ctrl & bus.writedata[1];
    assign w_w1c_done = w_wr & (bus.address == 2'd1) & bus.writedata[1];

    // The pin flop is loaded from the post-write manual settings so the pin
    // moves on the same edge that captures the CTRL write.
    assign w_manual_en_nxt  = w_wr_ctrl ? bus.writedata[3] : r_manual_en;
    assign w_manual_lvl_nxt = w_wr_ctrl ? bus.writedata[4] : r_manual_lvl;
    assign w_idle_pin       = w_manual_en_nxt ? w_manual_lvl_nxt : 1'b1;

    // A zero length still yields one cycle so the sequence always advances.
    assign w_pulse_load   = (r_pulse_len   == 24'd0) ? 24'd1 : r_pulse_len;
    assign w_recover_load = (r_recover_len == 24'd0) ? 24'd1 : r_recover_len;

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en      <= 1'b0;
            r_manual_en   <= 1'b1;
            r_manual_lvl  <= 1'b0;
            r_pulse_len   <= PULSE_DEFAULT;
            r_recover_len <= RECOVER_DEFAULT;
        end else if (w_wr) begin
            case (bus.address)
                2'd0: begin
                    r_irq_en     <= bus.writedata[2];
                    r_manual_en  <= bus.writedata[3];
                    r_manual_lvl <= bus.writedata[4];
                end
                2'd2:    r_pulse_len   <= bus.writedata[23:0];
                2'd3:    r_recover_len <= bus.writedata[23:0];
                default: ;
            endcase
        end
    end

    // Sequencer FSM: state, down-counter, DONE flag and the registered pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_count     <= 24'd0;
            r_done      <= 1'b0;
            r_otg_rst_n <= 1'b0;
        end else begin
            // A DONE set below overrides this clear when both land together.
            if (w_w1c_done) r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start && !w_abort && !w_manual_en_nxt) begin
                        r_state     <= ASSERT;
                        r_count     <= w_pulse_load;
                        r_otg_rst_n <= 1'b0;
                    end else begin
                        r_otg_rst_n <= w_idle_pin;
                    end
                end
                ASSERT: begin
                    if (w_abort) begin
                        r_state     <= IDLE;
                        r_count     <= 24'd0;
                        r_otg_rst_n <= w_idle_pin;
                    end else if (r_count == 24'd1) begin
                        r_state     <= RECOVER;
                        r_count     <= w_recover_load;
                        r_otg_rst_n <= 1'b1;
                    end else begin
                        r_count     <= r_count - 24'd1;
                        r_otg_rst_n <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (w_abort) begin
                        r_state     <= IDLE;
                        r_count     <= 24'd0;
                        r_otg_rst_n <= w_idle_pin;
                    end else if (r_count == 24'd1) begin
                        r_state     <= IDLE;
                        r_count     <= 24'd0;
                        r_done      <= 1'b1;
                        r_otg_rst_n <= w_idle_pin;
                    end else begin
                        r_count     <= r_count - 24'd1;
                        r_otg_rst_n <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_count     <= 24'd0;
                    r_otg_rst_n <= w_idle_pin;
                end
            endcase
        end
    end

    assign otg_rst_n = r_otg_rst_n;
    assign irq       = r_done & r_irq_en;

    // Zero-wait-state read mux; START and ABORT always read back as 0.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {27'd0, r_manual_lvl, r_manual_en, r_irq_en, 2'b00};
            2'd1: bus.readdata = {28'd0, r_state, r_done, (r_state != IDLE)};
            2'd2: bus.readdata = {8'd0, r_pulse_len};
            2'd3: bus.readdata = {8'd0, r_recover_len};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/usb_rst_sequencer.md
# usb_rst_sequencer

Avalon-MM slave that owns the USB OTG controller's active-low reset line and generates a timed reset pulse followed by a recovery hold-off. Software sets pulse and recovery lengths and triggers one sequence instead of bit-banging the reset pin. A manual mode drives the pin as a plain output bit.

## Interface
- PULSE_DEFAULT, 24'd50000, reset value of PULSE_LEN: 1 ms at 50 MHz.
- RECOVER_DEFAULT, 24'd500000, reset value of RECOVER_LEN: 10 ms at 50 MHz.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect & ~write_n.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero wait states.
- otg_rst_n  out  1  registered reset line to the USB controller.
- irq  out  1  level interrupt: DONE & IRQ_EN.

## Operation
- Registers:
  - addr 0, CTRL: b0 START (write-1 pulse, reads 0); b1 ABORT (write-1 pulse, reads 0); b2 IRQ_EN; b3 MANUAL_EN; b4 MANUAL_LVL.
  - addr 1, STATUS (read): b0 BUSY; b1 DONE; b[3:2] state code (IDLE=0, ASSERT=1, RECOVER=2). Writing 1 to b1 clears DONE.
  - addr 2, PULSE_LEN: bits [23:0], R/W.
  - addr 3, RECOVER_LEN: bits [23:0], R/W.
  - Unused read bits are 0.
- Reset values: state IDLE, counter 0, DONE 0, IRQ_EN 0, MANUAL_EN 1, MANUAL_LVL 0, PULSE_LEN = PULSE_DEFAULT, RECOVER_LEN = RECOVER_DEFAULT.
  - otg_rst_n = 0 and irq = 0. The USB controller stays held in reset until software acts.
- otg_rst_n by state:
  - IDLE: MANUAL_EN ? MANUAL_LVL : 1.
  - ASSERT: 0.
  - RECOVER: 1.
- FSM:
  - IDLE -> ASSERT on START when MANUAL_EN = 0 and ABORT = 0 in the same write. The counter loads max(PULSE_LEN, 1).
  - ASSERT: the counter decrements each cycle. At count 1, go to RECOVER and load max(RECOVER_LEN, 1).
  - RECOVER: the counter decrements. At count 1, go to IDLE and set DONE.
- Length values are sampled only at counter load. Writes to PULSE_LEN or RECOVER_LEN mid-sequence affect the next load only.
- START while BUSY is ignored.
- START while MANUAL_EN = 1 is ignored.
- ABORT in ASSERT or RECOVER: go to IDLE next edge, DONE unchanged. ABORT in IDLE has no effect.
- START and ABORT in the same write: ABORT wins.
- MANUAL_EN/MANUAL_LVL written while BUSY: the registers update immediately, but they affect the pin only once the FSM is back in IDLE.
- DONE set and a W1C in the same cycle: set wins.
- Asynchronous reset mid-sequence: the FSM returns immediately to IDLE with reset values, so otg_rst_n = 0 (manual, low).

## Timing
- A write is sampled at rising edge N. Register and FSM updates are visible after edge N, and readdata reflects them from cycle N+1.
- START accepted at edge N: otg_rst_n is 0 from edge N through edge N+P, where P = max(PULSE_LEN, 1). That is exactly P cycles low.
- otg_rst_n returns to 1 at edge N+P.
- BUSY stays 1 and DONE becomes 1 at edge N+P+R, where R = max(RECOVER_LEN, 1).
- irq rises in the same cycle as DONE when IRQ_EN = 1.
- otg_rst_n is driven from a flop and is glitch-free.

## Test plan
- Reset release -> otg_rst_n = 0, irq = 0, STATUS = 0, PULSE_LEN reads 50000, RECOVER_LEN reads 500000.
- Write CTRL = 0x00 -> otg_rst_n = 1 next cycle. Then PULSE_LEN = 5, RECOVER_LEN = 3, CTRL = 0x05 -> otg_rst_n low for exactly 5 cycles, then DONE and irq rise 3 cycles later, and STATUS = 0x2. W1C STATUS b1 -> irq drops next cycle.
- PULSE_LEN = 0, RECOVER_LEN = 0, START -> 1 cycle low, 1 cycle recovery, DONE set.
- START, then ABORT 2 cycles later -> otg_rst_n = 1 on the next edge, STATUS = 0, DONE stays 0. A second START mid-sequence -> cycle count unchanged.
- MANUAL_EN = 1 with MANUAL_LVL toggling 0/1 -> pin follows one cycle after each write, and START is ignored.
- Assert reset_n during RECOVER -> immediate IDLE, otg_rst_n = 0, registers return to defaults.
